// File: rtl/rk_kbd_pkg.sv
// Shared constants for the keyboard frame receiver.
// Frame layout, modifier bit positions, UART states, matrix type.
package rk_kbd_pkg;

    localparam int FRAME_LEN = 9;
    localparam int MOD_IDX   = 8;
    localparam int MOD_SHIFT = 0;
    localparam int MOD_CTRL  = 1;
    localparam int MOD_RUS   = 2;
    localparam int MOD_RST   = 7;

    localparam logic [1:0] UART_IDLE  = 2'd0;
    localparam logic [1:0] UART_START = 2'd1;
    localparam logic [1:0] UART_DATA  = 2'd2;
    localparam logic [1:0] UART_STOP  = 2'd3;

    typedef logic [7:0][7:0] kbd_matrix_t;

endpackage

// File: rtl/rk_uart_rx.sv
// UART 8N1 receiver with input synchronizer.
// Emits a one-cycle valid on a good stop bit, ferr on a bad one.
module rk_uart_rx
    import rk_kbd_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       I_CLK,
    input  logic       I_RESET,
    input  logic       I_RX,
    output logic [7:0] O_DATA,
    output logic       O_VALID,
    output logic       O_FERR
);

    localparam int BIT_CNT = CLK_HZ / BAUD;
    localparam int HALF    = BIT_CNT / 2;
    localparam int CW      = $clog2(BIT_CNT);

    logic [2:0]    r_sync;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_valid;
    logic          r_ferr;
    logic          w_rx;
    logic          w_fall;
    logic          w_full;

    assign w_rx   = r_sync[1];
    assign w_fall = r_sync[2] & ~r_sync[1];
    assign w_full = (r_cnt == CW'(BIT_CNT - 1));

    // Two-flop synchronizer plus one delayed copy for edge detect
    always_ff @(posedge I_CLK) begin
        if (I_RESET) r_sync <= 3'b111;
        else         r_sync <= {r_sync[1:0], I_RX};
    end

    // Bit-timing FSM: mid-bit sampling from the start edge
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_state <= UART_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                UART_IDLE: begin
                    r_cnt <= '0;
                    if (w_fall) r_state <= UART_START;
                end
                UART_START: begin
                    if (r_cnt == CW'(HALF - 1)) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= w_rx ? UART_IDLE : UART_DATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                UART_DATA: begin
                    if (w_full) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) r_state <= UART_STOP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    if (w_full) begin
                        r_cnt   <= '0;
                        r_valid <= w_rx;
                        r_ferr  <= ~w_rx;
                        r_state <= UART_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    assign O_DATA  = r_shift;
    assign O_VALID = r_valid;
    assign O_FERR  = r_ferr;

endmodule

// File: rtl/rk_kbd_frame_rx.sv
// Keyboard frame assembler, key matrix and PPA scan responder.
// Frames are shadowed and committed atomically on the modifier byte.
module rk_kbd_frame_rx
    import rk_kbd_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int TIMEOUT_MS = 100
) (
    input  logic       I_CLK,
    input  logic       I_RESET,
    input  logic       I_RX,
    input  logic       I_NEWFRAME,
    input  logic [7:0] I_ADDR,
    output logic [7:0] O_DATA,
    output logic [2:0] O_SHIFT,
    output logic       O_K_RESET
);

    localparam longint TO_CNT =
        longint'(TIMEOUT_MS) * longint'(CLK_HZ) / 64'sd1000;
    localparam int TO_W = $clog2(TO_CNT + 1);

    logic [7:0]      w_byte;
    logic            w_valid;
    logic            w_ferr;
    logic            w_nf_rise;
    logic            w_commit;
    logic            w_to_hit;
    logic [7:0]      w_or;
    logic [2:0]      r_nf;
    logic [3:0]      r_idx;
    logic            r_bad;
    kbd_matrix_t     r_shadow;
    kbd_matrix_t     r_row;
    logic [2:0]      r_mod;
    logic            r_krst;
    logic [TO_W-1:0] r_to;

    rk_uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_uart (
        .I_CLK   (I_CLK),
        .I_RESET (I_RESET),
        .I_RX    (I_RX),
        .O_DATA  (w_byte),
        .O_VALID (w_valid),
        .O_FERR  (w_ferr)
    );

    // Frame marker synchronizer with rising-edge detect
    always_ff @(posedge I_CLK) begin
        if (I_RESET) r_nf <= '0;
        else         r_nf <= {r_nf[1:0], I_NEWFRAME};
    end

    assign w_nf_rise = r_nf[1] & ~r_nf[2];
    assign w_commit  = w_valid & ~w_nf_rise & ~r_bad
                     & (r_idx == 4'(MOD_IDX));
    assign w_to_hit  = (r_to == TO_W'(TO_CNT));

    // Byte index, bad-frame flag and shadow rows
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_idx    <= '0;
            r_bad    <= 1'b0;
            r_shadow <= '0;
        end else if (w_nf_rise) begin
            r_idx <= '0;
            r_bad <= 1'b0;
        end else begin
            if (w_ferr) r_bad <= 1'b1;
            if (w_valid && r_idx < 4'(MOD_IDX)) begin
                r_shadow[r_idx[2:0]] <= w_byte;
                r_idx                <= r_idx + 4'd1;
            end else if (w_valid && r_idx == 4'(MOD_IDX)) begin
                r_idx <= 4'(FRAME_LEN);
            end
        end
    end

    // Live matrix: atomic commit, released on timeout
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_row  <= '0;
            r_mod  <= '0;
            r_krst <= 1'b0;
        end else if (w_commit) begin
            r_row  <= r_shadow;
            r_mod  <= {w_byte[MOD_RUS], w_byte[MOD_CTRL],
                       w_byte[MOD_SHIFT]};
            r_krst <= w_byte[MOD_RST];
        end else if (w_to_hit) begin
            r_row  <= '0;
            r_mod  <= '0;
            r_krst <= 1'b0;
        end
    end

    // Silence counter since last commit, saturating
    always_ff @(posedge I_CLK) begin
        if (I_RESET)       r_to <= '0;
        else if (w_commit) r_to <= '0;
        else if (!w_to_hit) r_to <= r_to + TO_W'(1);
    end

    // Scan: OR the columns of every selected row
    always_comb begin
        w_or = '0;
        for (int i = 0; i < 8; i++) begin
            if (!I_ADDR[i]) w_or = w_or | r_row[i];
        end
    end

    assign O_DATA    = ~w_or;
    assign O_SHIFT   = ~r_mod;
    assign O_K_RESET = r_krst;

endmodule

// File: tb/tb_rk_kbd_frame_rx.sv
// Bench for rk_kbd_frame_rx: UART frames against a queue-based model.
// Scaled clock/baud so timeout fits a short run.
module tb_rk_kbd_frame_rx;

    localparam int CLK_HZ = 4000000;
    localparam int BAUD   = 400000;
    localparam int TMS    = 1;
    localparam int BITC   = CLK_HZ / BAUD;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       nf;
    logic [7:0] addr;
    logic [7:0] dout;
    logic [2:0] shift;
    logic       krst;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_row [8];
    logic [2:0] m_mod;
    logic       m_krst;
    logic [7:0] q [$];
    bit         m_bad;
    bit         m_done;

    always #5 clk = ~clk;

    rk_kbd_frame_rx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .TIMEOUT_MS (TMS)
    ) dut (
        .I_CLK      (clk),
        .I_RESET    (rst),
        .I_RX       (rx),
        .I_NEWFRAME (nf),
        .I_ADDR     (addr),
        .O_DATA     (dout),
        .O_SHIFT    (shift),
        .O_K_RESET  (krst)
    );

    task automatic m_clear();
        for (int i = 0; i < 8; i++) m_row[i] = 8'h00;
        m_mod  = 3'b000;
        m_krst = 1'b0;
    endtask

    task automatic m_newframe();
        q.delete();
        m_bad  = 0;
        m_done = 0;
    endtask

    task automatic m_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            m_bad = 1;
        end else if (!m_done) begin
            q.push_back(b);
            if (q.size() == 9) begin
                m_done = 1;
                if (!m_bad) begin
                    for (int i = 0; i < 8; i++) m_row[i] = q[i];
                    m_mod  = {q[8][2], q[8][1], q[8][0]};
                    m_krst = q[8][7];
                end
            end
        end
    endtask

    function automatic logic [7:0] exp_scan(input logic [7:0] a);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (!a[i] && m_row[i][j]) p[j] = 1'b1;
        return ~p;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scan(input string tag, input logic [7:0] a);
        @(negedge clk);
        addr = a;
        #1;
        chk({tag, "_scan"}, dout, exp_scan(a));
    endtask

    task automatic check_all(input string tag);
        logic [7:0] r;
        scan(tag, 8'h00);
        scan(tag, 8'hFF);
        scan(tag, 8'hFE);
        scan(tag, 8'h7F);
        scan(tag, 8'h7E);
        r = 8'($urandom);
        scan(tag, r);
        chk({tag, "_shift"}, {5'd0, shift}, {5'd0, ~m_mod});
        chk({tag, "_krst"}, {7'd0, krst}, {7'd0, m_krst});
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok);
        logic [9:0] w;
        w = {ok ? 1'b1 : 1'b0, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx = w[k];
            repeat (BITC) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BITC) @(negedge clk);
        m_byte(b, ok);
    endtask

    task automatic newframe();
        nf = 1'b1;
        repeat (4) @(negedge clk);
        nf = 1'b0;
        repeat (4) @(negedge clk);
        m_newframe();
    endtask

    task automatic send_frame(input logic [8:0][7:0] f, input int badpos);
        newframe();
        for (int i = 0; i < 9; i++) send_byte(f[i], i != badpos);
    endtask

    task automatic rand_frame(output logic [8:0][7:0] f);
        for (int i = 0; i < 9; i++) f[i] = 8'($urandom);
    endtask

    initial begin
        logic [8:0][7:0] f;
        logic [8:0][7:0] f1;
        bit prev_bad;
        int bp;
        rst  = 1'b1;
        rx   = 1'b1;
        nf   = 1'b0;
        addr = 8'hFF;
        m_clear();
        m_newframe();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        check_all("t1_reset");

        f1 = '0;
        f1[0] = 8'h01;
        f1[7] = 8'h80;
        f1[8] = 8'h01;
        send_frame(f1, -1);
        check_all("t2_frame");
        scan("t2_fe", 8'hFE);
        chk("t2_fe_const", dout, 8'hFE);
        chk("t2_shift_const", {5'd0, shift}, 8'h06);

        rand_frame(f);
        send_frame(f, 3);
        check_all("t3_badframe");
        rand_frame(f);
        send_frame(f, -1);
        check_all("t3_clean");

        newframe();
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1);
        f = '0;
        f[8] = 8'h80;
        send_frame(f, -1);
        check_all("t4_restart");
        chk("t4_krst_const", {7'd0, krst}, 8'h01);

        prev_bad = 0;
        for (int n = 0; n < 8; n++) begin
            rand_frame(f);
            bp = -1;
            if (!prev_bad && $urandom_range(0, 3) == 0)
                bp = int'($urandom_range(0, 8));
            prev_bad = (bp >= 0);
            send_frame(f, bp);
            check_all("rnd");
        end

        send_frame(f1, -1);
        check_all("t5_pre");
        repeat (3700) @(negedge clk);
        check_all("t5_hold");
        repeat (500) @(negedge clk);
        m_clear();
        check_all("t5_timeout");

        rand_frame(f);
        newframe();
        for (int i = 0; i < 3; i++) send_byte(f[i], 1);
        rx = 1'b0;
        repeat (BITC / 2 - 1) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BITC) @(negedge clk);
        for (int i = 3; i < 9; i++) send_byte(f[i], 1);
        check_all("t6_glitch");

        rand_frame(f);
        newframe();
        for (int i = 0; i < 3; i++) send_byte(f[i], 1);
        rx = 1'b0;
        repeat (BITC + BITC / 2 + 3) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_clear();
        m_newframe();
        repeat (12 * BITC) @(negedge clk);
        check_all("t6_reset");
        for (int i = 3; i < 8; i++) send_byte(f[i], 1);
        check_all("t6_partial");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
